fp_div_seq: RTL and testbench

- Half-precision floating-point divider. It is the inverse-operation companion to the team's pipelined FP multiplier and uses the same 1/5/10 format with bias 15.
- It is an iterative radix-2 restoring divider with a valid/ready handshake on both sides.
- It produces one quotient per operation with round-to-nearest-even and normalization.
- It sits beside the multiplier in the arithmetic datapath and feeds the same downstream result bus.

---
 rtl/fp16_pkg.sv | 15 +
 rtl/fp16_norm_round.sv | 30 +++
 rtl/fp_div_seq.sv | 117 +++++++++++
 tb/tb_fp_div_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared half-precision format constants, divider states and operand struct
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam int DIV_CYC = MAN_W + 4;
  localparam logic [MAN_W-1:0] QNAN_MAN = 10'h200;
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} div_state_t;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;
endpackage

// File: rtl/fp16_norm_round.sv
// fp16_norm_round: combinational normalize, round-to-nearest-even and range clamp
// Takes a 14-bit quotient with weight 2^0 at the MSB plus a sticky remainder flag.
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic [MAN_W+3:0]   i_q,
  input  logic               i_rem_nz,
  input  logic signed [6:0]  i_exp,
  output logic [EXP_W-1:0]   o_exp,
  output logic [MAN_W-1:0]   o_man,
  output logic               o_ovf,
  output logic               o_unf
);
  logic [MAN_W+3:0] w_qn;
  logic signed [6:0] w_en;
  logic signed [6:0] w_er;
  logic [MAN_W:0] w_mr;
  logic w_inc;
  always_comb begin
    w_qn = i_q[MAN_W+3] ? i_q : i_q << 1;
    w_en = i_q[MAN_W+3] ? i_exp : i_exp - 7'sd1;
    w_inc = w_qn[2] & (w_qn[1] | w_qn[0] | i_rem_nz | w_qn[3]);
    w_mr = {1'b0, w_qn[MAN_W+2:3]} + {{MAN_W{1'b0}}, w_inc};
    w_er = w_mr[MAN_W] ? w_en + 7'sd1 : w_en;
    o_ovf = w_er >= $signed(7'(EXP_MAX));
    o_unf = w_er <= 7'sd0;
    o_exp = o_ovf ? EXP_W'(EXP_MAX) : o_unf ? '0 : w_er[EXP_W-1:0];
    o_man = (o_ovf | o_unf) ? '0 : w_mr[MAN_W-1:0];
  end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative radix-2 restoring half-precision divider with valid/ready handshakes
// FP_DIV_EARLY_OUT_EN: special operands bypass DIV/ROUND and complete one cycle after accept.
module fp_div_seq
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             q_sign,
  output logic [EXP_W-1:0] q_exp,
  output logic [MAN_W-1:0] q_man,
  output logic             flag_dbz,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_nv
);
`ifdef FP_DIV_EARLY_OUT_EN
  localparam logic EARLY_OUT = 1'b1;
`else
  localparam logic EARLY_OUT = 1'b0;
`endif
  div_state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [MAN_W+1:0] r_rem;
  logic [MAN_W:0] r_mb;
  logic [MAN_W+3:0] r_q;
  logic signed [6:0] r_exp;
  logic r_sign, r_spec;
  fp16_t r_spec_res, r_res, w_spec_res;
  logic [3:0] r_spec_flags, r_flags;
  logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic w_nv, w_dbz, w_inf, w_zero, w_spec, w_acc, w_ge;
  logic [EXP_W-1:0] w_nr_exp;
  logic [MAN_W-1:0] w_nr_man;
  logic w_nr_ovf, w_nr_unf;
  assign w_a_zero = a_exp == '0;
  assign w_a_inf = a_exp == EXP_W'(EXP_MAX) && a_man == '0;
  assign w_a_nan = a_exp == EXP_W'(EXP_MAX) && a_man != '0;
  assign w_b_zero = b_exp == '0;
  assign w_b_inf = b_exp == EXP_W'(EXP_MAX) && b_man == '0;
  assign w_b_nan = b_exp == EXP_W'(EXP_MAX) && b_man != '0;
  // Special-case priority: invalid, divide-by-zero, infinite quotient, zero quotient.
  assign w_nv = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
  assign w_dbz = ~w_nv & w_b_zero & ~w_a_zero & ~w_a_inf;
  assign w_inf = w_dbz | (~w_nv & w_a_inf);
  assign w_zero = ~w_nv & ~w_inf & (w_b_inf | w_a_zero);
  assign w_spec = w_nv | w_inf | w_zero;
  assign w_spec_res = '{sign: a_sign ^ b_sign,
                        exp:  (w_nv | w_inf) ? EXP_W'(EXP_MAX) : '0,
                        man:  w_nv ? QNAN_MAN : '0};
  assign w_acc = in_valid & (r_state == IDLE);
  assign w_ge = r_rem >= {1'b0, r_mb};
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = !in_valid ? IDLE : (EARLY_OUT && w_spec) ? DONE : DIV;
      DIV:   w_next = (r_cnt == 4'(DIV_CYC - 1)) ? ROUND : DIV;
      ROUND: w_next = DONE;
      DONE:  w_next = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_res <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_rem <= {1'b0, 1'b1, a_man};
        r_mb <= {1'b1, b_man};
        r_q <= '0;
        r_cnt <= '0;
        r_exp <= 7'(a_exp) - 7'(b_exp) + 7'(BIAS);
        r_sign <= a_sign ^ b_sign;
        r_spec <= w_spec;
        r_spec_res <= w_spec_res;
        r_spec_flags <= {w_dbz, 2'b00, w_nv};
        r_flags <= (EARLY_OUT && w_spec) ? {w_dbz, 2'b00, w_nv} : '0;
        if (EARLY_OUT && w_spec) r_res <= w_spec_res;
      end
      if (r_state == DIV) begin
        r_q <= {r_q[MAN_W+2:0], w_ge};
        r_rem <= (w_ge ? r_rem - {1'b0, r_mb} : r_rem) << 1;
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == ROUND) begin
        r_res <= r_spec ? r_spec_res : '{sign: r_sign, exp: w_nr_exp, man: w_nr_man};
        r_flags <= r_spec ? r_spec_flags : {1'b0, w_nr_ovf, w_nr_unf, 1'b0};
      end
    end
  end
  fp16_norm_round u_nr (
    .i_q      (r_q),
    .i_rem_nz (|r_rem),
    .i_exp    (r_exp),
    .o_exp    (w_nr_exp),
    .o_man    (w_nr_man),
    .o_ovf    (w_nr_ovf),
    .o_unf    (w_nr_unf)
  );
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign q_sign = r_res.sign;
  assign q_exp = r_res.exp;
  assign q_man = r_res.man;
  assign {flag_dbz, flag_ovf, flag_unf, flag_nv} = r_flags;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed and model-checked bench for the half-precision divider
module tb_fp_div_seq;
`ifdef FP_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 16;
`endif
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [15:0] a = '0, b = '0;
  logic q_sign, flag_dbz, flag_ovf, flag_unf, flag_nv;
  logic [4:0] q_exp;
  logic [9:0] q_man;
  int n_tests = 0, n_fail = 0;
  logic [19:0] exp_q[$];

  fp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a[15]), .a_exp(a[14:10]), .a_man(a[9:0]),
    .b_sign(b[15]), .b_exp(b[14:10]), .b_man(b[9:0]),
    .out_valid(out_valid), .out_ready(out_ready),
    .q_sign(q_sign), .q_exp(q_exp), .q_man(q_man),
    .flag_dbz(flag_dbz), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_nv(flag_nv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Result as {dbz, ovf, unf, nv, sign, exp, man}, from exact integer division.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
    logic s;
    logic [4:0] ex, ey;
    logic [9:0] mx, my;
    logic xz, xi, xn, yz, yi, yn;
    int na, nb, e, k, qi, rr;
    s = x[15] ^ y[15];
    ex = x[14:10]; ey = y[14:10]; mx = x[9:0]; my = y[9:0];
    xz = ex == 0; xi = ex == 31 && mx == 0; xn = ex == 31 && mx != 0;
    yz = ey == 0; yi = ey == 31 && my == 0; yn = ey == 31 && my != 0;
    if (xn || yn || (xz && yz) || (xi && yi)) return {4'b0001, s, 5'd31, 10'h200};
    if (yz && !xz && !xi) return {4'b1000, s, 5'd31, 10'd0};
    if (xi) return {4'b0000, s, 5'd31, 10'd0};
    if (yi || xz) return {4'b0000, s, 5'd0, 10'd0};
    na = 1024 + int'(mx);
    nb = 1024 + int'(my);
    e = int'(ex) - int'(ey) + 15;
    k = 10;
    if (na < nb) begin
      k = 11;
      e = e - 1;
    end
    qi = (na << k) / nb;
    rr = (na << k) % nb;
    if (2 * rr > nb || (2 * rr == nb && qi % 2 == 1)) qi = qi + 1;
    if (qi == 2048) begin
      qi = 1024;
      e = e + 1;
    end
    if (e >= 31) return {4'b0100, s, 5'd31, 10'd0};
    if (e <= 0) return {4'b0010, s, 5'd0, 10'd0};
    return {4'b0000, s, 5'(e), 10'(qi)};
  endfunction

  // Compare process: every cycle a result is presented it must match the oldest expectation.
  initial forever begin
    @(negedge clk);
    #2;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 20'd1, 20'd0);
      else begin
        check("dut_vs_model", {flag_dbz, flag_ovf, flag_unf, flag_nv, q_sign, q_exp, q_man}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] lit,
                      input logic [3:0] flit, input int lat_req, input bit use_lit);
    int n, lat;
    if (use_lit) check($sformatf("model_%h_%h", x, y), model(x, y), {flit, lit});
    @(negedge clk);
    a = x; b = y; in_valid = 1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 20'(in_ready), 20'd1);
    exp_q.push_back(model(x, y));
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_%h_%h", x, y), 20'(lat), 20'(lat_req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_outputs", {flag_dbz, flag_ovf, flag_unf, flag_nv, q_sign, q_exp, q_man}, 20'd0);
    check("reset_in_ready", 20'(in_ready), 20'd1);
    check("reset_out_valid", 20'(out_valid), 20'd0);
    send(16'h3E00, 16'h3800, 16'h4200, 4'b0000, 16, 1);
    send(16'h3C00, 16'h4200, 16'h3555, 4'b0000, 16, 1);
    send(16'h4600, 16'h3E00, 16'h4400, 4'b0000, 16, 1);
    send(16'h3C00, 16'h0000, 16'h7C00, 4'b1000, SPEC_LAT, 1);
    send(16'h0000, 16'h0000, 16'h7E00, 4'b0001, SPEC_LAT, 1);
    send(16'hBC00, 16'h7C00, 16'h8000, 4'b0000, SPEC_LAT, 1);
    send(16'h7BFF, 16'h1400, 16'h7C00, 4'b0100, 16, 1);
    send(16'h0400, 16'h7800, 16'h0000, 4'b0010, 16, 1);
    send(16'h7C00, 16'h4000, 16'h7C00, 4'b0000, SPEC_LAT, 1);
    for (int i = 0; i < 12; i++)
      send({1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)},
           {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)}, 16'h0, 4'h0, 16, 0);
    // Backpressure: result must hold and new operands must be refused.
    @(negedge clk);
    out_ready = 0;
    send(16'hC200, 16'h3E00, 16'hC000, 4'b0000, 16, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'h4000; b = 16'h3C00; in_valid = 1;
      check("hold_in_ready", 20'(in_ready), 20'd0);
      check("hold_out_valid", 20'(out_valid), 20'd1);
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("after_handshake_out_valid", 20'(out_valid), 20'd0);
    check("after_handshake_in_ready", 20'(in_ready), 20'd1);
    // Reset in the middle of a division aborts it.
    a = 16'h3E00; b = 16'h3800; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_in_ready", 20'(in_ready), 20'd1);
    check("abort_out_valid", 20'(out_valid), 20'd0);
    exp_q.delete();
    send(16'h4000, 16'h4000, 16'h3C00, 4'b0000, 16, 1);
    repeat (3) @(negedge clk);
    check("queue_drained", 20'(exp_q.size()), 20'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
